// File: rtl/pcs_fifo_pkg.sv
// Shared definitions for the PCS FIFO family: read-mode constants and a
// constant-foldable ceil(log2) used to size pointers and the fill level.
package pcs_fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module param_fifo_mem
    import pcs_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/param_synch_fifo.sv
// Single-clock FIFO for PCS code-group buffering: arbitrary depth, programmable
// almost-empty/almost-full, standard or first-word-fall-through read mode.
module param_synch_fifo
    import pcs_fifo_pkg::*;
#(
    parameter int unsigned WIDTH         = 10,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned AEMPTY_THRESH = 1,
    parameter int unsigned AFULL_THRESH  = 6,
    parameter int unsigned FWFT          = FIFO_STD
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           write_en,
    input  logic                           read_en,
    output logic [WIDTH-1:0]               data_out,
    output logic                           dout_valid,
    output logic                           fifo_empty,
    output logic                           fifo_aempty,
    output logic                           fifo_afull,
    output logic                           fifo_full,
    output logic [clog2(DEPTH+1)-1:0]      fill_level,
    output logic                           overflow,
    output logic                           underflow,
    output logic                           error_sticky
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = clog2(DEPTH + 1);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_error;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_rd_data;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_rd_ok = read_en & ~w_empty;
    assign w_wr_ok = write_en & (~w_full | w_rd_ok);

    param_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (w_wr_ok & ~reset & ~clear),
        .wr_addr (r_wr_ptr),
        .wr_data (data_in),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // Pointers, level, standard-mode output register and error reporting.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
                r_dout   <= w_rd_data;
            end
            r_dout_valid <= w_rd_ok;
            if (w_wr_ok && !w_rd_ok) begin
                r_level <= r_level + LW'(1);
            end else if (w_rd_ok && !w_wr_ok) begin
                r_level <= r_level - LW'(1);
            end
            r_overflow  <= write_en & ~w_wr_ok;
            r_underflow <= read_en & ~w_rd_ok;
            if ((write_en && !w_wr_ok) || (read_en && !w_rd_ok)) begin
                r_error <= 1'b1;
            end
        end
    end

    // FWFT presents the head word directly; standard mode uses the register.
    assign data_out   = (FWFT == FIFO_FWFT) ? w_rd_data : r_dout;
    assign dout_valid = (FWFT == FIFO_FWFT) ? ~w_empty  : r_dout_valid;

    assign fifo_empty   = w_empty;
    assign fifo_full    = w_full;
    assign fifo_aempty  = (r_level <= LW'(AEMPTY_THRESH));
    assign fifo_afull   = (r_level >= LW'(AFULL_THRESH));
    assign fill_level   = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign error_sticky = r_error;

endmodule

// File: tb/tb_param_synch_fifo.sv
// Scenario bench for param_synch_fifo: three instances (DEPTH=8 standard,
// DEPTH=5 standard, DEPTH=8 FWFT) checked against a queue scoreboard.
module tb_param_synch_fifo;
    import pcs_fifo_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    logic [9:0] q[$];
    logic [9:0] exp_d;

    // Instance A: DEPTH=8, standard mode
    logic       a_reset, a_clear, a_we, a_re;
    logic [9:0] a_din, a_dout;
    logic       a_dv, a_empty, a_aempty, a_afull, a_full, a_ovf, a_udf, a_err;
    logic [3:0] a_level;

    param_synch_fifo #(.WIDTH(10), .DEPTH(8), .AEMPTY_THRESH(1), .AFULL_THRESH(6), .FWFT(FIFO_STD)) u_a (
        .clock(clock), .reset(a_reset), .clear(a_clear), .data_in(a_din),
        .write_en(a_we), .read_en(a_re), .data_out(a_dout), .dout_valid(a_dv),
        .fifo_empty(a_empty), .fifo_aempty(a_aempty), .fifo_afull(a_afull),
        .fifo_full(a_full), .fill_level(a_level), .overflow(a_ovf),
        .underflow(a_udf), .error_sticky(a_err));

    // Instance B: DEPTH=5, standard mode
    logic       b_reset, b_we, b_re;
    logic [9:0] b_din, b_dout;
    logic       b_dv, b_empty, b_aempty, b_afull, b_full, b_ovf, b_udf, b_err;
    logic [2:0] b_level;

    param_synch_fifo #(.WIDTH(10), .DEPTH(5), .AEMPTY_THRESH(1), .AFULL_THRESH(4), .FWFT(FIFO_STD)) u_b (
        .clock(clock), .reset(b_reset), .clear(1'b0), .data_in(b_din),
        .write_en(b_we), .read_en(b_re), .data_out(b_dout), .dout_valid(b_dv),
        .fifo_empty(b_empty), .fifo_aempty(b_aempty), .fifo_afull(b_afull),
        .fifo_full(b_full), .fill_level(b_level), .overflow(b_ovf),
        .underflow(b_udf), .error_sticky(b_err));

    // Instance C: DEPTH=8, FWFT
    logic       c_reset, c_we, c_re;
    logic [9:0] c_din, c_dout;
    logic       c_dv, c_empty, c_aempty, c_afull, c_full, c_ovf, c_udf, c_err;
    logic [3:0] c_level;

    param_synch_fifo #(.WIDTH(10), .DEPTH(8), .AEMPTY_THRESH(1), .AFULL_THRESH(6), .FWFT(FIFO_FWFT)) u_c (
        .clock(clock), .reset(c_reset), .clear(1'b0), .data_in(c_din),
        .write_en(c_we), .read_en(c_re), .data_out(c_dout), .dout_valid(c_dv),
        .fifo_empty(c_empty), .fifo_aempty(c_aempty), .fifo_afull(c_afull),
        .fifo_full(c_full), .fill_level(c_level), .overflow(c_ovf),
        .underflow(c_udf), .error_sticky(c_err));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        tick();
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        checks++;
        if ({a_empty, a_aempty, a_afull, a_full} !== 4'b1100) begin
            failures++; $display("FAIL reset_flags got=%b want=1100", {a_empty, a_aempty, a_afull, a_full});
        end
        checks++;
        if (a_level !== 4'd0 || a_dv !== 1'b0 || a_dout !== 10'd0 || a_err !== 1'b0) begin
            failures++; $display("FAIL reset_state level=%0d dv=%b dout=%h err=%b", a_level, a_dv, a_dout, a_err);
        end
        checks++;
        if (c_dv !== 1'b0 || c_empty !== 1'b1 || b_empty !== 1'b1) begin
            failures++; $display("FAIL reset_bc c_dv=%b c_empty=%b b_empty=%b", c_dv, c_empty, b_empty);
        end
    endtask

    task automatic test_fill;
        q.delete();
        for (int i = 1; i <= 8; i++) begin
            a_we = 1'b1; a_din = 10'(i); q.push_back(10'(i));
            tick();
            checks++;
            if (a_level !== 4'(i) || a_afull !== (i >= 6) || a_full !== (i == 8) || a_ovf !== 1'b0) begin
                failures++;
                $display("FAIL fill_%0d level=%0d afull=%b full=%b ovf=%b", i, a_level, a_afull, a_full, a_ovf);
            end
        end
        a_din = 10'h3FF;
        tick();
        a_we = 1'b0;
        checks++;
        if (a_ovf !== 1'b1 || a_err !== 1'b1 || a_level !== 4'd8) begin
            failures++; $display("FAIL overflow ovf=%b err=%b level=%0d want 1 1 8", a_ovf, a_err, a_level);
        end
        tick();
        checks++;
        if (a_ovf !== 1'b0 || a_err !== 1'b1) begin
            failures++; $display("FAIL ovf_pulse ovf=%b err=%b want 0 1", a_ovf, a_err);
        end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 8; i++) begin
            a_re = 1'b1;
            tick();
            exp_d = q.pop_front();
            checks++;
            if (a_dv !== 1'b1 || a_dout !== exp_d) begin
                failures++; $display("FAIL drain_%0d dv=%b dout=%h want %h", i, a_dv, a_dout, exp_d);
            end
        end
        tick();
        a_re = 1'b0;
        checks++;
        if (a_udf !== 1'b1 || a_dv !== 1'b0 || a_empty !== 1'b1 || a_level !== 4'd0) begin
            failures++; $display("FAIL underflow udf=%b dv=%b empty=%b level=%0d", a_udf, a_dv, a_empty, a_level);
        end
        tick();
        checks++;
        if (a_udf !== 1'b0) begin
            failures++; $display("FAIL udf_pulse udf=%b want 0", a_udf);
        end
    endtask

    task automatic test_wrap;
        int max_level;
        max_level = 0;
        q.delete();
        for (int i = 0; i < 12; i++) begin
            b_we = 1'b1; b_din = 10'(12'h100 + i); q.push_back(10'(12'h100 + i));
            tick();
            b_we = 1'b0;
            if (int'(b_level) > max_level) max_level = int'(b_level);
            b_re = 1'b1;
            tick();
            b_re = 1'b0;
            exp_d = q.pop_front();
            checks++;
            if (b_dv !== 1'b1 || b_dout !== exp_d || b_level !== 3'd0) begin
                failures++; $display("FAIL wrap_%0d dv=%b dout=%h want %h level=%0d", i, b_dv, b_dout, exp_d, b_level);
            end
        end
        checks++;
        if (max_level !== 1) begin
            failures++; $display("FAIL wrap_maxlevel got=%0d want 1", max_level);
        end
    endtask

    task automatic test_back_to_back;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            a_we = 1'b1; a_din = 10'(8'h10 + i); q.push_back(10'(8'h10 + i));
            tick();
        end
        a_re = 1'b1; a_din = 10'h0AA; q.push_back(10'h0AA);
        tick();
        exp_d = q.pop_front();
        a_we = 1'b0;
        checks++;
        if (a_level !== 4'd8 || a_ovf !== 1'b0 || a_dout !== exp_d || a_dv !== 1'b1) begin
            failures++; $display("FAIL rw_full level=%0d ovf=%b dout=%h want %h", a_level, a_ovf, a_dout, exp_d);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_d = q.pop_front();
            checks++;
            if (a_dv !== 1'b1 || a_dout !== exp_d) begin
                failures++; $display("FAIL rw_drain_%0d dout=%h want %h", i, a_dout, exp_d);
            end
        end
        a_we = 1'b1; a_din = 10'h055; q.push_back(10'h055);
        tick();
        a_we = 1'b0; a_re = 1'b0;
        checks++;
        if (a_udf !== 1'b1 || a_level !== 4'd1 || a_dv !== 1'b0 || a_ovf !== 1'b0) begin
            failures++; $display("FAIL rw_empty udf=%b level=%0d dv=%b ovf=%b", a_udf, a_level, a_dv, a_ovf);
        end
        a_re = 1'b1;
        tick();
        a_re = 1'b0;
        exp_d = q.pop_front();
        checks++;
        if (a_dout !== exp_d || a_dv !== 1'b1 || a_empty !== 1'b1) begin
            failures++; $display("FAIL rw_empty_data dout=%h want %h empty=%b", a_dout, exp_d, a_empty);
        end
    endtask

    task automatic test_fwft;
        q.delete();
        c_we = 1'b1; c_din = 10'h2AA; q.push_back(10'h2AA);
        tick();
        c_we = 1'b0;
        exp_d = q[0];
        checks++;
        if (c_dv !== 1'b1 || c_dout !== exp_d || c_level !== 4'd1) begin
            failures++; $display("FAIL fwft_visible dv=%b dout=%h want %h", c_dv, c_dout, exp_d);
        end
        tick();
        checks++;
        if (c_dv !== 1'b1 || c_dout !== exp_d) begin
            failures++; $display("FAIL fwft_hold dv=%b dout=%h want %h", c_dv, c_dout, exp_d);
        end
        c_re = 1'b1;
        tick();
        c_re = 1'b0;
        void'(q.pop_front());
        checks++;
        if (c_dv !== 1'b0 || c_empty !== 1'b1 || c_udf !== 1'b0) begin
            failures++; $display("FAIL fwft_pop dv=%b empty=%b udf=%b", c_dv, c_empty, c_udf);
        end
    endtask

    task automatic test_clear_reset;
        // a is empty with error_sticky already set from the earlier underflow
        for (int i = 0; i < 5; i++) begin
            a_we = 1'b1; a_din = 10'(10'h200 + i);
            tick();
        end
        a_we = 1'b0;
        checks++;
        if (a_level !== 4'd5 || a_err !== 1'b1) begin
            failures++; $display("FAIL pre_clear level=%0d err=%b want 5 1", a_level, a_err);
        end
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        checks++;
        if (a_level !== 4'd0 || a_empty !== 1'b1 || a_err !== 1'b0 || a_dv !== 1'b0) begin
            failures++; $display("FAIL clear level=%0d empty=%b err=%b dv=%b", a_level, a_empty, a_err, a_dv);
        end
        a_re = 1'b1;
        tick();
        a_re = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_we = 1'b1; a_din = 10'(10'h300 + i);
            tick();
        end
        a_we = 1'b0;
        a_re = 1'b1;
        tick();
        a_re = 1'b0;
        checks++;
        if (a_level !== 4'd5 || a_err !== 1'b1 || a_dout !== 10'h300) begin
            failures++; $display("FAIL pre_reset level=%0d err=%b dout=%h want 5 1 300", a_level, a_err, a_dout);
        end
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        checks++;
        if (a_level !== 4'd0 || a_empty !== 1'b1 || a_err !== 1'b0 || a_dout !== 10'd0 || a_dv !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid level=%0d empty=%b err=%b dout=%h dv=%b", a_level, a_empty, a_err, a_dout, a_dv);
        end
        a_we = 1'b1; a_din = 10'h123;
        tick();
        a_we = 1'b0; a_re = 1'b1;
        tick();
        a_re = 1'b0;
        checks++;
        if (a_dout !== 10'h123 || a_dv !== 1'b1) begin
            failures++; $display("FAIL post_reset dout=%h want 123 dv=%b", a_dout, a_dv);
        end
    endtask

    initial begin
        a_reset = 1'b1; a_clear = 1'b0; a_we = 1'b0; a_re = 1'b0; a_din = '0;
        b_reset = 1'b1; b_we = 1'b0; b_re = 1'b0; b_din = '0;
        c_reset = 1'b1; c_we = 1'b0; c_re = 1'b0; c_din = '0;
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_fwft();
        test_clear_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
